// File: rtl/coef_pkg.sv
// Shared constants and FSM encoding for the writable coefficient table.
package coef_pkg;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    // Encoding 2'd3 is illegal; the loader maps it back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/coef_ram_core.sv
// DEPTH x DATA_W table with one write port and two registered read ports.
module coef_ram_core #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata1_r;
    logic [DATA_W-1:0] rdata2_r;

    // Table write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered reads see the pre-write word when addresses collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata1_r <= {DATA_W{1'b0}};
            rdata2_r <= {DATA_W{1'b0}};
        end else begin
            rdata1_r <= mem_r[raddr1];
            rdata2_r <= mem_r[raddr2];
        end
    end

    assign rdata1 = rdata1_r;
    assign rdata2 = rdata2_r;
endmodule

// File: rtl/coef_ram_loader.sv
// Loads DEPTH words from a valid/ready stream into the coefficient table and serves two read ports.
module coef_ram_loader #(
    parameter int DATA_W = coef_pkg::DATA_W,
    parameter int ADDR_W = coef_pkg::ADDR_W,
    parameter int DEPTH  = coef_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              loaded,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [DATA_W-1:0] dout1,
    output logic [DATA_W-1:0] dout2
);
    import coef_pkg::*;

    state_e            state_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic              wr_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              loaded_r;
    logic              handshake_s;
    logic              last_s;

    assign handshake_s = wr_ready_r & wr_valid;
    assign last_s      = (wr_ptr_r == ADDR_W'(DEPTH - 1));

    // Load sequencer; status flags are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= {ADDR_W{1'b0}};
            wr_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            loaded_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r    <= ST_LOAD;
                        wr_ptr_r   <= {ADDR_W{1'b0}};
                        loaded_r   <= 1'b0;
                        wr_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (handshake_s) begin
                        if (last_s) begin
                            state_r    <= ST_DONE;
                            wr_ptr_r   <= {ADDR_W{1'b0}};
                            wr_ready_r <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_r  <= ST_IDLE;
                    done_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    loaded_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wr_ptr_r   <= {ADDR_W{1'b0}};
                    wr_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    coef_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .we     (handshake_s),
        .waddr  (wr_ptr_r),
        .wdata  (wr_data),
        .raddr1 (addr1),
        .raddr2 (addr2),
        .rdata1 (dout1),
        .rdata2 (dout2)
    );

    assign wr_ready = wr_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign loaded   = loaded_r;
endmodule

// File: tb/tb_coef_ram_loader.sv
// Directed bench for coef_ram_loader: load, stall, read-during-write, abort and ignored start.
module tb_coef_ram_loader;
    logic        clk;
    logic        rst;
    logic        start;
    logic        wr_valid;
    logic [63:0] wr_data;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        loaded;
    logic [2:0]  addr1;
    logic [2:0]  addr2;
    logic [63:0] dout1;
    logic [63:0] dout2;

    logic [63:0] exp_mem [8];
    int          n_checks;
    int          n_fail;

    coef_ram_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done),
        .loaded   (loaded),
        .addr1    (addr1),
        .addr2    (addr2),
        .dout1    (dout1),
        .dout2    (dout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            addr1 = 3'(i);
            addr2 = 3'(7 - i);
            tick();
            check_eq({tag, "_dout1"}, dout1, exp_mem[i]);
            check_eq({tag, "_dout2"}, dout2, exp_mem[7 - i]);
        end
    endtask

    task automatic load_full(input string tag, input logic [63:0] base);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({tag, "_ready"}, {63'd0, wr_ready}, 64'd1);
        check_eq({tag, "_busy"}, {63'd0, busy}, 64'd1);
        check_eq({tag, "_loaded_clr"}, {63'd0, loaded}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 64'(i);
            tick();
            exp_mem[i] = base + 64'(i);
            check_eq({tag, "_done"}, {63'd0, done}, (i == 7) ? 64'd1 : 64'd0);
        end
        wr_valid = 1'b0;
        tick();
        check_eq({tag, "_done_end"}, {63'd0, done}, 64'd0);
        check_eq({tag, "_loaded"}, {63'd0, loaded}, 64'd1);
        check_eq({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] old2;
        int          done_cnt;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        addr1    = 3'd0;
        addr2    = 3'd0;

        // 1. reset with wr_valid high
        tick(); tick(); tick();
        check_eq("rst_ready", {63'd0, wr_ready}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_loaded", {63'd0, loaded}, 64'd0);
        check_eq("rst_dout1", dout1, 64'd0);
        check_eq("rst_dout2", dout2, 64'd0);
        rst      = 1'b0;
        wr_valid = 1'b0;
        tick();
        check_eq("idle_ready", {63'd0, wr_ready}, 64'd0);

        // 2. full load and crossed read-back
        load_full("load1", 64'h1111_0000_0000_0000);
        read_all("read1");

        // 3. stalled stream after word 3
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 64'h2222_0000_0000_0000 + 64'(i);
            tick();
            exp_mem[i] = 64'h2222_0000_0000_0000 + 64'(i);
        end
        wr_valid = 1'b0;
        wr_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        addr1    = 3'd4;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("stall_ptr", {61'd0, dut.wr_ptr_r}, 64'd4);
            check_eq("stall_busy", {63'd0, busy}, 64'd1);
            check_eq("stall_done", {63'd0, done}, 64'd0);
        end
        check_eq("stall_nowrite", dout1, 64'h1111_0000_0000_0004);
        for (int i = 4; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = 64'h2222_0000_0000_0000 + 64'(i);
            tick();
            exp_mem[i] = 64'h2222_0000_0000_0000 + 64'(i);
            check_eq("stall_done_pulse", {63'd0, done}, (i == 7) ? 64'd1 : 64'd0);
        end
        wr_valid = 1'b0;
        tick();
        check_eq("stall_loaded", {63'd0, loaded}, 64'd1);
        read_all("read2");

        // 4. read-during-write on address 2, then same-address reads
        old2  = exp_mem[2];
        addr1 = 3'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = 64'h3333_0000_0000_0000 + 64'(i);
            tick();
            exp_mem[i] = 64'h3333_0000_0000_0000 + 64'(i);
            if (i == 2) check_eq("rdw_old", dout1, old2);
            if (i == 3) check_eq("rdw_new", dout1, exp_mem[2]);
        end
        wr_valid = 1'b0;
        tick();
        addr1 = 3'd5;
        addr2 = 3'd5;
        tick();
        check_eq("same_addr1", dout1, exp_mem[5]);
        check_eq("same_addr2", dout2, exp_mem[5]);

        // 5. abort after four words of a reload
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 64'h4444_0000_0000_0000 + 64'(i);
            tick();
            exp_mem[i] = 64'h4444_0000_0000_0000 + 64'(i);
        end
        wr_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_loaded", {63'd0, loaded}, 64'd0);
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_ready", {63'd0, wr_ready}, 64'd0);
        read_all("abort_read");
        check_eq("abort_loaded_hold", {63'd0, loaded}, 64'd0);
        load_full("load5", 64'h5555_0000_0000_0000);
        read_all("read5");

        // 6. start during LOAD and in the final-handshake cycle is ignored
        start = 1'b1;
        tick();
        start    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = 64'h6666_0000_0000_0000 + 64'(i);
            start    = (i == 3 || i == 7) ? 1'b1 : 1'b0;
            tick();
            exp_mem[i] = 64'h6666_0000_0000_0000 + 64'(i);
            if (done) done_cnt++;
        end
        start    = 1'b0;
        wr_data  = 64'hBADB_ADBA_DBAD_BADB;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done) done_cnt++;
        end
        wr_valid = 1'b0;
        check_eq("ign_done_count", 64'(done_cnt), 64'd1);
        check_eq("ign_busy", {63'd0, busy}, 64'd0);
        check_eq("ign_ready", {63'd0, wr_ready}, 64'd0);
        check_eq("ign_loaded", {63'd0, loaded}, 64'd1);
        read_all("read6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
